// File: rtl/add_seq_wide.sv
// Sequential wide adder: streams 16*NSLICE-bit operands through one 16-bit CLA core, one slice per cycle.
// Optional subtract support is enabled by defining ADD_SEQ_SUB_EN.

module cla_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c0,
  output logic [15:0] sum,
  output logic        c16
);

  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] c;
  logic [3:0]  gg;
  logic [3:0]  gp;
  logic [4:0]  gc;

  // Bit generate/propagate
  assign g = a & b;
  assign p = a ^ b;

  // Group generate/propagate for each 4-bit block
  always_comb begin
    gg = 4'b0000;
    gp = 4'b0000;
    for (int j = 0; j < 4; j++) begin
      gg[j] = g[4*j+3]
            | (p[4*j+3] & g[4*j+2])
            | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      gp[j] = &p[4*j +: 4];
    end
  end

  // Second-level lookahead produces the carry into each block
  always_comb begin
    gc    = 5'b00000;
    gc[0] = c0;
    gc[1] = gg[0] | (gp[0] & c0);
    gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c0);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
          | (gp[2] & gp[1] & gp[0] & c0);
    gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
          | (gp[3] & gp[2] & gp[1] & gg[0])
          | (gp[3] & gp[2] & gp[1] & gp[0] & c0);
  end

  // First-level lookahead inside each block
  always_comb begin
    c = 16'h0000;
    for (int j = 0; j < 4; j++) begin
      c[4*j]   = gc[j];
      c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
      c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & gc[j]);
      c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
               | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
    end
  end

  assign sum = p ^ c;
  assign c16 = gc[4];

endmodule

module add_seq_wide #(
  parameter int NSLICE = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [16*NSLICE-1:0] in_a,
  input  logic [16*NSLICE-1:0] in_b,
  input  logic                 in_cin,
  input  logic                 in_sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [16*NSLICE-1:0] out_sum,
  output logic                 out_cout,
  output logic                 out_ovf
);

  localparam int W  = 16 * NSLICE;
  localparam int IW = $clog2(NSLICE);
  localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  sum_q;
  logic          carry_q;

  logic [W-1:0]  b_eff;
  logic [15:0]   core_a;
  logic [15:0]   core_b;
  logic [15:0]   core_sum;
  logic          core_c16;
  logic          ovf_next;

`ifdef ADD_SEQ_SUB_EN
  // Subtraction loads the one's complement of B; the caller supplies the +1 via in_cin
  always_comb begin
    b_eff = in_b;
    if (in_sub) begin
      b_eff = ~in_b;
    end else begin
      b_eff = in_b;
    end
  end
`else
  logic unused_sub;
  assign unused_sub = in_sub;

  // Without subtract support B passes straight through
  always_comb begin
    b_eff = in_b;
  end
`endif

  // Slice mux into the core, driven only from registered state
  always_comb begin
    core_a = a_q[{idx, 4'b0000} +: 16];
    core_b = b_q[{idx, 4'b0000} +: 16];
  end

  cla_16bit u_core (
    .a   (core_a),
    .b   (core_b),
    .c0  (carry_q),
    .sum (core_sum),
    .c16 (core_c16)
  );

  // Signed overflow of the full-width result, valid when the MSB slice is on the core
  always_comb begin
    ovf_next = (a_q[W-1] == b_q[W-1]) && (core_sum[15] != a_q[W-1]);
  end

  // Control FSM, slice datapath and registered handshake/result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      carry_q   <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= in_a;
            b_q      <= b_eff;
            carry_q  <= in_cin;
            idx      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
          end
        end
        RUN: begin
          sum_q[{idx, 4'b0000} +: 16] <= core_sum;
          carry_q                     <= core_c16;
          if (idx == LAST) begin
            out_sum   <= {core_sum, sum_q[W-17:0]};
            out_cout  <= core_c16;
            out_ovf   <= ovf_next;
            out_valid <= 1'b1;
            idx       <= '0;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          idx       <= '0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_add_seq_wide.sv
// Self-checking bench for add_seq_wide (NSLICE=4): directed vectors, handshake corners and random ops.
// Expectations for subtract depend on ADD_SEQ_SUB_EN, matching the RTL build.

module tb_add_seq_wide;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic        in_cin;
  logic        in_sub;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_sum;
  logic        out_cout;
  logic        out_ovf;

  int checks = 0;
  int errors = 0;

  add_seq_wide #(.NSLICE(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic        sub;
    logic [63:0] exp_sum;
    logic        exp_cout;
    logic        exp_ovf;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: wide two's-complement arithmetic straight from the definition
  function automatic logic [65:0] model(input logic [63:0] a, input logic [63:0] b,
                                        input logic cin, input logic sub);
    logic [63:0] be;
    logic [64:0] full;
    logic        ovf;
    be = b;
`ifdef ADD_SEQ_SUB_EN
    if (sub) be = ~b;
`endif
    full = {1'b0, a} + {1'b0, be} + {64'd0, cin};
    ovf  = (a[63] == be[63]) && (full[63] != a[63]);
    return {ovf, full};
  endfunction

  // Accept one operand and wait for the result; checks accept-readiness and latency
  task automatic run_op(input string name, input logic [63:0] a, input logic [63:0] b,
                        input logic cin, input logic sub);
    int lat;
    check({name, "_ready"}, {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_sub   = sub;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a     = {$urandom(), $urandom()};
    in_b     = {$urandom(), $urandom()};
    in_cin   = 1'($urandom());
    in_sub   = 1'($urandom());
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({name, "_latency"}, 64'(lat), 64'd4);
  endtask

  task automatic release_result(input string name);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({name, "_ready_back"}, {63'd0, in_ready}, 64'd1);
    check({name, "_valid_low"}, {63'd0, out_valid}, 64'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    check({name, "_out_valid"}, {63'd0, out_valid}, 64'd0);
    check({name, "_out_sum"}, out_sum, 64'd0);
    check({name, "_out_cout"}, {63'd0, out_cout}, 64'd0);
    check({name, "_out_ovf"}, {63'd0, out_ovf}, 64'd0);
  endtask

  vec_t        vecs[6];
  logic [65:0] ref_r;
  logic [63:0] ra;
  logic [63:0] rb;
  logic        rc;
  logic        rs;
  logic [63:0] held;

  initial begin
    vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0};
    vecs[1] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vecs[2] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'd0, 1'b1, 1'b1};
    vecs[3] = '{64'd0, 64'd0, 1'b1, 1'b0, 64'd1, 1'b0, 1'b0};
    vecs[4] = '{64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 1'b0,
                64'h0001_0000_0001_0000, 1'b0, 1'b0};
`ifdef ADD_SEQ_SUB_EN
    vecs[5] = '{64'd5, 64'd7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
`else
    vecs[5] = '{64'd5, 64'd7, 1'b1, 1'b1, 64'd13, 1'b0, 1'b0};
`endif

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = 64'd0;
    in_b      = 64'd0;
    in_cin    = 1'b0;
    in_sub    = 1'b0;
    out_ready = 1'b0;
    #12;
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
      check($sformatf("vec%0d_sum", i), out_sum, vecs[i].exp_sum);
      check($sformatf("vec%0d_cout", i), {63'd0, out_cout}, {63'd0, vecs[i].exp_cout});
      check($sformatf("vec%0d_ovf", i), {63'd0, out_ovf}, {63'd0, vecs[i].exp_ovf});
      release_result($sformatf("vec%0d", i));
    end

    // Backpressure: result held, further requests ignored
    run_op("bp", 64'd20000, 64'd25555, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_a     = {$urandom(), $urandom()};
      in_b     = {$urandom(), $urandom()};
      @(posedge clk);
      #1;
      check($sformatf("bp_hold%0d_sum", k), out_sum, 64'd45555);
      check($sformatf("bp_hold%0d_valid", k), {63'd0, out_valid}, 64'd1);
      check($sformatf("bp_hold%0d_in_ready", k), {63'd0, in_ready}, 64'd0);
    end
    in_valid = 1'b0;
    release_result("bp");
    @(posedge clk);
    #1;
    check("bp_no_second_accept", {63'd0, in_ready}, 64'd1);

    // Reset in the middle of RUN with a nonzero previous result on the outputs
    run_op("pre", 64'd1234, 64'd4321, 1'b0, 1'b0);
    check("pre_sum", out_sum, 64'd5555);
    release_result("pre");
    in_valid = 1'b1;
    in_a     = 64'hFFFF_0000_FFFF_0000;
    in_b     = 64'h0001_0001_0001_0001;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    check_reset_outputs("midrun");
    @(posedge clk);
    #1;
    check_reset_outputs("midrun_hold");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_op("post", 64'd150, 64'd130, 1'b0, 1'b0);
    check("post_sum", out_sum, 64'd280);
    check("post_cout", {63'd0, out_cout}, 64'd0);
    release_result("post");

    // Random operands against the arithmetic model, with random consumer stalls
    for (int i = 0; i < 40; i++) begin
      ra = {$urandom(), $urandom()};
      rb = {$urandom(), $urandom()};
      if (i % 4 == 0) rb = ~ra;
      rc = 1'($urandom());
      rs = 1'($urandom());
      ref_r = model(ra, rb, rc, rs);
      run_op($sformatf("rnd%0d", i), ra, rb, rc, rs);
      held = out_sum;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      check($sformatf("rnd%0d_sum", i), out_sum, ref_r[63:0]);
      check($sformatf("rnd%0d_stable", i), out_sum, held);
      check($sformatf("rnd%0d_cout", i), {63'd0, out_cout}, {63'd0, ref_r[64]});
      check($sformatf("rnd%0d_ovf", i), {63'd0, out_ovf}, {63'd0, ref_r[65]});
      release_result($sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
